bcd_display_scanner: RTL
========================

// Module: bcd_display_scanner
// PURPOSE
//  Consumes the 4-bit BCD outputs of cascaded decade counters and drives a multiplexed
//  common-anode-style 7-segment display, one digit per refresh slot. Sits directly
//  downstream of the decade counter chain. Double-buffers the value so a display frame never tears.
// PARAMETERS
//  NUM_DIGITS   4     number of BCD digits scanned (>=2)
//  REFRESH_DIV  1000  clk cycles per digit slot (>=2); prescaler width = $clog2(REFRESH_DIV)
//  BLANK_LEAD   1     1 = blank leading zeros, 0 = show all digits
// PORTS
//  clk      in   1              system clock, all logic on posedge
//  reset_n  in   1              synchronous, active-low reset
//  load     in   1              strobe: capture bcd_in/dp_in this cycle
//  bcd_in   in   4*NUM_DIGITS   digit i at [4i+3:4i]; digit 0 = least significant
//  dp_in    in   NUM_DIGITS     decimal point request per digit
//  seg      out  7              segments, active-high, seg[0]=a .. seg[6]=g (registered)
//  dp       out  1              decimal point of current digit, active-high (registered)
//  an       out  NUM_DIGITS     digit enable, one-hot active-high (registered)
//  frame_done out 1             1-cycle pulse when digit index wraps NUM_DIGITS-1 -> 0
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): prescaler=0, idx=0, disp_reg=0, disp_dp=0, pend=0,
//    seg=0, dp=0, an=0, frame_done=0. All outputs off for exactly the reset cycles.
//  - Prescaler: counts 0..REFRESH_DIV-1, wraps to 0; tick=1 when count==REFRESH_DIV-1.
//  - On tick: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1. On wrap: frame_done=1 next cycle.
//  - Capture: load=1 -> pend_val<=bcd_in, pend_dp<=dp_in, pend<=1; latest load wins.
//  - Commit at wrap cycle only: if load=1 same cycle, commit bcd_in/dp_in directly and
//    leave pend=0; else if pend=1, commit pend_val/pend_dp and clear pend; else hold.
//  - Load-to-visible latency: <= NUM_DIGITS*REFRESH_DIV + 1 cycles.
//  - Output regs update every cycle from current idx/disp_reg (1-cycle latency vs idx):
//    an=1<<idx; seg=encode(digit[idx]); dp=disp_dp[idx].
//  - Encoding: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; 10-15 -> 40 ('-').
//  - Blanking (BLANK_LEAD=1): digit i>0 blanked (seg=00) if digits NUM_DIGITS-1..i are all
//    zero and disp_dp[i]=0; an still asserted; dp still driven. Digit 0 never blanked.
//  - Reset mid-frame: everything returns to reset values; pending load discarded.
// STRUCTURE
//  - Package display_pkg: SEG_* segment constants, SEG_DASH=7'h40, SEG_BLANK=7'h00.
//  - Sub-module bcd_to_seg7 (combinational, 4b in -> 7b out, invalid -> SEG_DASH);
//    one instance, muxed input. Blank mask computed in top as a NUM_DIGITS-bit vector.
// TESTING (bench uses NUM_DIGITS=4, REFRESH_DIV=4)
//  1 Reset release, no load -> an cycles 0001,0010,0100,1000 every 4 clk; seg=3F on
//    digit0, 00 on digits1-3; frame_done pulses every 16 clk.
//  2 load bcd_in=16'h1234 mid-frame -> unchanged until wrap; next frame seg 4F,5B,06? no:
//    digit0=4:66, digit1=3:4F, digit2=2:5B, digit3=1:06.
//  3 load 16'h0070, dp_in=4'b0100 -> digit0 3F, digit1 07, digit2 00 with dp=1 shown as
//    3F (not blanked), digit3 00.
//  4 load 16'h00A9 -> digit0 6F, digit1 40, digits2-3 blank.
//  5 load on exact wrap cycle with 16'h5555 while pend holds 16'h1111 -> frame shows 6D x4,
//    pend=0; and two loads in one frame -> only second value displayed.
//  6 reset_n=0 for 1 clk mid-frame after load -> an=0,seg=0 that cycle, then digit0 shows 3F.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - segment patterns shared by the BCD display scanner
package display_pkg;

    // seg[0]=a .. seg[6]=g, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to 7-segment encoder
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - double-buffered multiplexed 7-segment scanner for BCD counters
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter bit BLANK_LEAD  = 1'b1
)
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp_reg;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend;

    logic                    tick;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    all_zero;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              enc_seg;

    assign tick = (presc == PRESC_MAX);
    assign wrap = tick && (idx == IDX_MAX);

    // A digit is a leading zero only if it and every digit above it are zero.
    always_comb begin
        blank    = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero && (disp_reg[4*i +: 4] == 4'd0);
            blank[i] = BLANK_LEAD && all_zero && !disp_dp[i];
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit = disp_reg[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = blank[i];
            end
        end
    end

    bcd_to_seg7 u_enc (
        .bcd (cur_digit),
        .seg (enc_seg)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc      <= '0;
            idx        <= '0;
            disp_reg   <= '0;
            disp_dp    <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
            seg        <= SEG_BLANK;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end

            if (load) begin
                pend_val <= bcd_in;
                pend_dp  <= dp_in;
                pend     <= 1'b1;
            end

            // The visible value only changes between frames so a frame never tears.
            if (wrap) begin
                if (load) begin
                    disp_reg <= bcd_in;
                    disp_dp  <= dp_in;
                    pend     <= 1'b0;
                end else if (pend) begin
                    disp_reg <= pend_val;
                    disp_dp  <= pend_dp;
                    pend     <= 1'b0;
                end
            end

            an         <= NUM_DIGITS'(1) << idx;
            seg        <= cur_blank ? SEG_BLANK : enc_seg;
            dp         <= cur_dp;
            frame_done <= wrap;
        end
    end

endmodule
